// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-queue entry payload.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_store.sv
// Fetch-queue storage: DEPTH entries, two write ports, two combinational read ports.
module fq_store
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  fq_entry_t         wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  fq_entry_t         wd1,
  input  logic [AW-1:0]     ra0,
  output fq_entry_t         rd0,
  input  logic [AW-1:0]     ra1,
  output fq_entry_t         rd1
);

  fq_entry_t mem [DEPTH];

  // Write both halves of an accepted pair; the two addresses never collide.
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  // Zero-latency reads of the two oldest slots.
  always_comb begin
    rd0 = mem[ra0];
    rd1 = mem[ra1];
  end

endmodule

// File: rtl/fetch_queue.sv
// Two-wide instruction queue between imem and dec.
// Optional build macro FQ_STATS_EN adds stall_cycles / flush_cnt counters.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [W-1:0]               ins1,
  input  logic [W-1:0]               ins2,
  input  logic [W-1:0]               ipc,
  input  logic                       flush,
  input  logic [1:0]                 deq,
  output logic [W-1:0]               e,
  output logic [W-1:0]               f,
  output logic [W-1:0]               epc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       waitpc,
  output logic                       ovf_err
`ifdef FQ_STATS_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [15:0]                flush_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [1:0]    deq_lim;
  logic [1:0]    n;
  logic          illegal;
  logic          enq;
  fq_entry_t     wd0;
  fq_entry_t     wd1;
  fq_entry_t     rd0;
  fq_entry_t     rd1;

  // Accept/consume decisions, all from pre-edge count.
  always_comb begin
    deq_lim = (deq == 2'd3) ? 2'd2 : deq;
    n       = (CW'(deq_lim) > count) ? count[1:0] : deq_lim;
    illegal = (deq == 2'd3) || (CW'(deq) > count);
    enq     = in_valid && !flush && !rst && (count <= CW'(DEPTH - 2));
    waitpc  = count > CW'(DEPTH - 2);
    wd0     = '{pc: XLEN'(ipc),         instr: XLEN'(ins1)};
    wd1     = '{pc: XLEN'(ipc + W'(1)), instr: XLEN'(ins2)};
  end

  fq_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
    .clk (clk),
    .we0 (enq),
    .wa0 (wr_ptr),
    .wd0 (wd0),
    .we1 (enq),
    .wa1 (wr_ptr + AW'(1)),
    .wd1 (wd1),
    .ra0 (rd_ptr),
    .rd0 (rd0),
    .ra1 (rd_ptr + AW'(1)),
    .rd1 (rd1)
  );

  // Present oldest two entries, NOP when not enough are queued.
  always_comb begin
    e   = (count != '0)      ? W'(rd0.instr) : W'(NOP_INSTR);
    epc = (count != '0)      ? W'(rd0.pc)    : '0;
    f   = (count >= CW'(2))  ? W'(rd1.instr) : W'(NOP_INSTR);
  end

  // Pointer, occupancy and sticky error state; flush empties but keeps ovf_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(2);
      rd_ptr <= rd_ptr + AW'(n);
      count  <= count + (enq ? CW'(2) : CW'(0)) - CW'(n);
      if (illegal) ovf_err <= 1'b1;
    end
  end

`ifdef FQ_STATS_EN
  // Saturating stall and flush event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cnt    <= '0;
    end else begin
      if (waitpc && in_valid && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (flush && (flush_cnt != '1))                 flush_cnt    <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=8, W=32).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] ins1, ins2, ipc;
  logic        flush;
  logic [1:0]  deq;
  logic [31:0] e, f, epc;
  logic [3:0]  count;
  logic        waitpc;
  logic        ovf_err;
`ifdef FQ_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(8), .W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .ins1     (ins1),
    .ins2     (ins2),
    .ipc      (ipc),
    .flush    (flush),
    .deq      (deq),
    .e        (e),
    .f        (f),
    .epc      (epc),
    .count    (count),
    .waitpc   (waitpc),
    .ovf_err  (ovf_err)
`ifdef FQ_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_cnt    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pair at pc carries 0x1000_0000|pc and 0x2000_0000|pc.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] d, input logic fl);
    in_valid = v;
    ipc      = pc;
    ins1     = 32'h1000_0000 | pc;
    ins2     = 32'h2000_0000 | pc;
    deq      = d;
    flush    = fl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 2'd0, 1'b0);
    step(); step();
    rst = 1'b0;
    chk("rst_e", e, 32'h0);
    chk("rst_f", f, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_waitpc", 32'(waitpc), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);

    // First pair
    drive(1'b1, 32'h10, 2'd0, 1'b0);
    ins1 = 32'hAAAA0001;
    ins2 = 32'hBBBB0002;
    step();
    chk("p1_e", e, 32'hAAAA0001);
    chk("p1_f", f, 32'hBBBB0002);
    chk("p1_epc", epc, 32'h10);
    chk("p1_count", 32'(count), 32'd2);

    // Fill to full, then a dropped pair
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 32'h10 + 32'(2 * k), 2'd0, 1'b0);
      step();
    end
    chk("full_count", 32'(count), 32'd8);
    chk("full_waitpc", 32'(waitpc), 32'd1);
    drive(1'b1, 32'h40, 2'd0, 1'b0);
    step();
    chk("drop_count", 32'(count), 32'd8);
    chk("drop_e", e, 32'hAAAA0001);

    drive(1'b0, 32'h0, 2'd2, 1'b0);
    step();
    chk("deq2_e", e, 32'h1000_0012);
    chk("deq2_f", f, 32'h2000_0012);
    chk("deq2_epc", epc, 32'h12);
    chk("deq2_count", 32'(count), 32'd6);
    chk("deq2_waitpc", 32'(waitpc), 32'd0);

    drive(1'b0, 32'h0, 2'd1, 1'b0);
    step();
    chk("deq1_count", 32'(count), 32'd5);
    chk("deq1_e", e, 32'h2000_0012);
    chk("deq1_epc", epc, 32'h13);

    drive(1'b1, 32'h50, 2'd0, 1'b0);
    step();
    chk("c7_count", 32'(count), 32'd7);
    chk("c7_waitpc", 32'(waitpc), 32'd1);

    // Full-minus-one: enqueue refused, dequeue proceeds
    drive(1'b1, 32'h60, 2'd1, 1'b0);
    step();
    chk("fm1_count", 32'(count), 32'd6);
    chk("fm1_e", e, 32'h1000_0014);
    chk("fm1_epc", epc, 32'h14);

    drive(1'b0, 32'h0, 2'd2, 1'b0);
    step(); step();
    chk("wrap_count", 32'(count), 32'd2);
    chk("wrap_e", e, 32'h1000_0050);
    chk("wrap_f", f, 32'h2000_0050);
    chk("wrap_epc", epc, 32'h50);
    step();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_e", e, 32'h0);
    chk("drain_waitpc", 32'(waitpc), 32'd0);

    // Steady state: pair in, two out, pointers wrap repeatedly
    drive(1'b1, 32'h100, 2'd0, 1'b0);
    step();
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 32'h100 + 32'(2 * k), 2'd2, 1'b0);
      step();
      chk("ss_count", 32'(count), 32'd2);
      chk("ss_epc", epc, 32'h100 + 32'(2 * k));
      chk("ss_e", e, 32'h1000_0100 + 32'(2 * k));
      chk("ss_f", f, 32'h2000_0100 + 32'(2 * k));
    end
    chk("ss_ovf", 32'(ovf_err), 32'd0);

    drive(1'b0, 32'h0, 2'd1, 1'b0);
    step();
    chk("one_f", f, 32'h0);
    chk("one_e", e, 32'h2000_0128);
    chk("one_epc", epc, 32'h129);

    drive(1'b1, 32'h300, 2'd0, 1'b0);
    step();
    chk("c3_count", 32'(count), 32'd3);

    // Flush with concurrent pair and dequeue
    drive(1'b1, 32'h400, 2'd2, 1'b1);
    step();
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_e", e, 32'h0);
    chk("fl_f", f, 32'h0);
    chk("fl_epc", epc, 32'h0);
    chk("fl_waitpc", 32'(waitpc), 32'd0);
    chk("fl_ovf", 32'(ovf_err), 32'd0);

    drive(1'b1, 32'h500, 2'd0, 1'b0);
    step();
    chk("pf_e", e, 32'h1000_0500);
    chk("pf_epc", epc, 32'h500);

    // Over-dequeue
    drive(1'b0, 32'h0, 2'd1, 1'b0);
    step();
    drive(1'b0, 32'h0, 2'd2, 1'b0);
    step();
    chk("ov_count", 32'(count), 32'd0);
    chk("ov_ovf", 32'(ovf_err), 32'd1);
    drive(1'b0, 32'h0, 2'd0, 1'b0);
    step();
    chk("ov_sticky", 32'(ovf_err), 32'd1);

    drive(1'b1, 32'h600, 2'd0, 1'b0);
    step();
    drive(1'b1, 32'h700, 2'd0, 1'b0);
    step();
    chk("d3_pre", 32'(count), 32'd4);
    drive(1'b0, 32'h0, 2'd3, 1'b0);
    step();
    chk("d3_count", 32'(count), 32'd2);
    chk("d3_ovf", 32'(ovf_err), 32'd1);
    chk("d3_e", e, 32'h1000_0700);
    chk("d3_epc", epc, 32'h700);

    drive(1'b0, 32'h0, 2'd0, 1'b1);
    step();
    chk("fl2_count", 32'(count), 32'd0);
    chk("fl2_ovf", 32'(ovf_err), 32'd1);

    drive(1'b0, 32'h0, 2'd0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_ovf", 32'(ovf_err), 32'd0);
    chk("rst2_count", 32'(count), 32'd0);

`ifdef FQ_STATS_EN
    chk("st_rst_stall", stall_cycles, 32'd0);
    chk("st_rst_flush", 32'(flush_cnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h800 + 32'(2 * k), 2'd0, 1'b0);
      step();
    end
    chk("st_fill_stall", stall_cycles, 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h900, 2'd0, 1'b0);
      step();
    end
    chk("st_stall", stall_cycles, 32'd5);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 2'd0, 1'b1);
      step();
    end
    chk("st_flush", 32'(flush_cnt), 32'd3);
    chk("st_stall_hold", stall_cycles, 32'd5);
    drive(1'b0, 32'h0, 2'd0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("st_clr_stall", stall_cycles, 32'd0);
    chk("st_clr_flush", 32'(flush_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
